// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer: engine command codes,
// sequencer states and per-step helpers.
package i2c_pkg;

    localparam logic [3:0] CMD_IDLE    = 4'd0;
    localparam logic [3:0] CMD_START   = 4'd1;
    localparam logic [3:0] CMD_RESTART = 4'd2;
    localparam logic [3:0] CMD_STOP    = 4'd3;
    localparam logic [3:0] CMD_WRITE   = 4'd4;
    localparam logic [3:0] CMD_READ    = 4'd5;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_REG, S_DATA_W,
        S_RESTART, S_DEV_R, S_READ, S_STOP, S_DONE
    } seq_state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_ISSUE, PH_WAIT} issue_phase_t;

    // Successor of a step when it completes cleanly.
    function automatic seq_state_t next_step(input seq_state_t st, input logic rw);
        case (st)
            S_START:   return S_DEV_W;
            S_DEV_W:   return S_REG;
            S_REG:     return (rw == RW_READ) ? S_RESTART : S_DATA_W;
            S_DATA_W:  return S_STOP;
            S_RESTART: return S_DEV_R;
            S_DEV_R:   return S_READ;
            S_READ:    return S_STOP;
            S_STOP:    return S_DONE;
            default:   return S_IDLE;
        endcase
    endfunction

    function automatic logic is_write_step(input seq_state_t st);
        return (st == S_DEV_W) || (st == S_REG) || (st == S_DATA_W) || (st == S_DEV_R);
    endfunction

    function automatic logic [3:0] step_cmd(input seq_state_t st);
        case (st)
            S_START:   return CMD_START;
            S_RESTART: return CMD_RESTART;
            S_STOP:    return CMD_STOP;
            S_READ:    return CMD_READ;
            S_DEV_W, S_REG, S_DATA_W, S_DEV_R: return CMD_WRITE;
            default:   return CMD_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] step_byte(input seq_state_t st, input logic [6:0] dev,
                                             input logic [7:0] reg_addr, input logic [7:0] wdata);
        case (st)
            S_DEV_W:  return {dev, RW_WRITE};
            S_REG:    return reg_addr;
            S_DATA_W: return wdata;
            S_DEV_R:  return {dev, RW_READ};
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_cmd_issue.sv
// One engine command: valid/ready issue, then wait for done, with a per-command
// timeout. Completion (done or timeout) is reported combinationally via o_fin.
module i2c_cmd_issue
    import i2c_pkg::*;
#(
    parameter logic [15:0] P_TIMEOUT = 16'd50000,
    parameter int          P_CNT_W   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_go,
    input  logic [3:0] i_cmd,
    input  logic [7:0] i_byte,
    input  logic       i_nack,
    output logic       o_cmd_valid,
    output logic [3:0] o_cmd,
    output logic [7:0] o_cmd_byte,
    output logic       o_cmd_nack,
    input  logic       i_cmd_ready,
    input  logic       i_cmd_done,
    input  logic       i_ack,
    input  logic [7:0] i_rd_byte,
    output logic       o_fin,
    output logic       o_fin_ack,
    output logic       o_fin_tmo,
    output logic [7:0] o_fin_byte
);

    localparam logic [P_CNT_W-1:0] TMO_LAST = P_CNT_W'(P_TIMEOUT - 16'd1);
    localparam logic [P_CNT_W-1:0] CNT_ONE  = P_CNT_W'(1);

    issue_phase_t       phase_q;
    logic [P_CNT_W-1:0] cnt_q;
    logic               valid_q;
    logic [3:0]         cmd_q;
    logic [7:0]         byte_q;
    logic               nack_q;
    logic               tmo_hit;
    logic               done_hit;

    // A done arriving on the last counted cycle still counts as completion.
    assign done_hit = (phase_q == PH_WAIT) && i_cmd_done;
    assign tmo_hit  = (phase_q != PH_IDLE) && (cnt_q == TMO_LAST);

    assign o_fin       = done_hit || tmo_hit;
    assign o_fin_tmo   = tmo_hit && !done_hit;
    assign o_fin_ack   = i_ack;
    assign o_fin_byte  = i_rd_byte;
    assign o_cmd_valid = valid_q;
    assign o_cmd       = cmd_q;
    assign o_cmd_byte  = byte_q;
    assign o_cmd_nack  = nack_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            cmd_q   <= CMD_IDLE;
            byte_q  <= 8'h00;
            nack_q  <= 1'b0;
        end else if (phase_q == PH_IDLE) begin
            if (i_go) begin
                phase_q <= PH_ISSUE;
                cnt_q   <= '0;
                valid_q <= 1'b1;
                cmd_q   <= i_cmd;
                byte_q  <= i_byte;
                nack_q  <= i_nack;
            end
        end else if (o_fin || (phase_q == PH_ISSUE && i_cmd_ready)) begin
            phase_q <= o_fin ? PH_IDLE : PH_WAIT;
            cnt_q   <= cnt_q + CNT_ONE;
            valid_q <= 1'b0;
            cmd_q   <= CMD_IDLE;
            nack_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Register-access transaction sequencer: turns one read/write request into the
// START/WRITE/RESTART/READ/STOP command sequence for the byte-level I2C engine.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter logic [15:0] P_TIMEOUT = 16'd50000,
    parameter int          P_CNT_W   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic       i_RW,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_W_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err_nack,
    output logic       o_err_tmo,
    output logic [7:0] o_R_data,
    output logic [3:0] o_cmd,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd_byte,
    output logic       o_cmd_nack,
    input  logic       i_cmd_ready,
    input  logic       i_cmd_done,
    input  logic       i_ack,
    input  logic [7:0] i_rd_byte
);

    seq_state_t state_q, step_next;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q, rdata_q;
    logic       busy_q, done_q, err_nack_q, err_tmo_q;
    logic       go_q, go_nack_q;
    logic [3:0] go_cmd_q;
    logic [7:0] go_byte_q;
    logic       fin, fin_ack, fin_tmo;
    logic [7:0] fin_byte;

    i2c_cmd_issue #(.P_TIMEOUT(P_TIMEOUT), .P_CNT_W(P_CNT_W)) u_issue (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_go(go_q), .i_cmd(go_cmd_q), .i_byte(go_byte_q), .i_nack(go_nack_q),
        .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_cmd_byte(o_cmd_byte), .o_cmd_nack(o_cmd_nack),
        .i_cmd_ready(i_cmd_ready), .i_cmd_done(i_cmd_done), .i_ack(i_ack), .i_rd_byte(i_rd_byte),
        .o_fin(fin), .o_fin_ack(fin_ack), .o_fin_tmo(fin_tmo), .o_fin_byte(fin_byte)
    );

    // Any failure diverts to STOP; a failing STOP itself is never retried.
    always_comb begin
        step_next = next_step(state_q, rw_q);
        if (fin_tmo)
            step_next = (state_q == S_STOP) ? S_DONE : S_STOP;
        else if (is_write_step(state_q) && !fin_ack)
            step_next = S_STOP;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            rw_q       <= RW_WRITE;
            dev_q      <= 7'h00;
            reg_q      <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_nack_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            go_q       <= 1'b0;
            go_cmd_q   <= CMD_IDLE;
            go_byte_q  <= 8'h00;
            go_nack_q  <= 1'b0;
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (i_req) begin
                    rw_q       <= i_RW;
                    dev_q      <= i_dev_addr;
                    reg_q      <= i_reg_addr;
                    wdata_q    <= i_W_data;
                    err_nack_q <= 1'b0;
                    err_tmo_q  <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_START;
                    go_q       <= 1'b1;
                    go_cmd_q   <= CMD_START;
                    go_byte_q  <= 8'h00;
                    go_nack_q  <= 1'b0;
                end
                S_DONE: state_q <= S_IDLE;
                default: if (fin) begin
                    state_q <= step_next;
                    if (fin_tmo)
                        err_tmo_q <= 1'b1;
                    else if (is_write_step(state_q) && !fin_ack)
                        err_nack_q <= 1'b1;
                    if (state_q == S_READ && !fin_tmo)
                        rdata_q <= fin_byte;
                    if (step_next == S_DONE) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        go_q      <= 1'b1;
                        go_cmd_q  <= step_cmd(step_next);
                        go_byte_q <= step_byte(step_next, dev_q, reg_q, wdata_q);
                        go_nack_q <= (step_next == S_READ);
                    end
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err_nack = err_nack_q;
    assign o_err_tmo  = err_tmo_q;
    assign o_R_data   = rdata_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench: behavioural I2C engine plus a transaction-level model of
// the expected command sequence, error flags and read data.
module tb_i2c_txn_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0, rw = 1'b0;
    logic [6:0] dev = 7'h00;
    logic [7:0] ra = 8'h00, wd = 8'h00;
    logic       busy, done, err_nack, err_tmo, cmd_valid, cmd_nack;
    logic [7:0] rdata, cmd_byte;
    logic [3:0] cmd;
    logic       cmd_ready = 1'b0, cmd_done = 1'b0, ack = 1'b0;
    logic [7:0] rd_byte = 8'h00;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.P_TIMEOUT(16'd20), .P_CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_RW(rw),
        .i_dev_addr(dev), .i_reg_addr(ra), .i_W_data(wd),
        .o_busy(busy), .o_done(done), .o_err_nack(err_nack), .o_err_tmo(err_tmo),
        .o_R_data(rdata), .o_cmd(cmd), .o_cmd_valid(cmd_valid), .o_cmd_byte(cmd_byte),
        .o_cmd_nack(cmd_nack), .i_cmd_ready(cmd_ready), .i_cmd_done(cmd_done),
        .i_ack(ack), .i_rd_byte(rd_byte)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine behaviour knobs, indexed by command position within a transaction.
    int          cfg_rdy = 0, cfg_dly = 1;
    logic [15:0] cfg_nack = 16'h0, cfg_stall = 16'h0;
    logic [7:0]  cfg_rd = 8'h00;

    logic [12:0] log_q[$];
    logic [12:0] exp_q[$];
    logic [12:0] pend = 13'h0;
    logic        eng_wait = 1'b0, eng_stalled = 1'b0, prev_valid = 1'b0, prev_tmo = 1'b0;
    int          eng_idx = 0, eng_cnt = 0, rdy_cnt = 0;
    int          rise_cyc = 0, tmo_delta = -1, done_pulses = 0, stab_viol = 0;

    always @(negedge clk) begin
        cmd_done = 1'b0;
        if (!rst_n) begin
            eng_wait = 1'b0; cmd_ready = 1'b0; rdy_cnt = 0; prev_valid = 1'b0; prev_tmo = 1'b0;
        end else begin
            if (done) done_pulses++;
            if (err_tmo && !prev_tmo && tmo_delta < 0) tmo_delta = cyc - rise_cyc;
            if (cmd_valid && !prev_valid) rise_cyc = cyc;
            if (cmd_ready && prev_valid) begin
                log_q.push_back(pend);
                eng_idx = log_q.size() - 1;
                cmd_ready = 1'b0; rdy_cnt = 0;
                eng_wait = 1'b1; eng_cnt = cfg_dly; eng_stalled = cfg_stall[eng_idx[3:0]];
            end else if (eng_wait) begin
                if (eng_stalled) begin
                    if (cmd_valid) eng_wait = 1'b0;
                end else if (eng_cnt > 1) begin
                    eng_cnt--;
                end else begin
                    cmd_done = 1'b1; ack = ~cfg_nack[eng_idx[3:0]]; rd_byte = cfg_rd; eng_wait = 1'b0;
                end
            end else if (cmd_valid) begin
                if (rdy_cnt == 0) pend = {cmd, cmd_byte, cmd_nack};
                else if ({cmd, cmd_byte, cmd_nack} !== pend) stab_viol++;
                if (rdy_cnt >= cfg_rdy) cmd_ready = 1'b1; else rdy_cnt++;
            end else begin
                rdy_cnt = 0;
            end
            prev_valid = cmd_valid; prev_tmo = err_tmo;
        end
    end

    task automatic chk(input string tag, input int got, input int expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Expected command list built from the transaction rules, not from RTL states.
    task automatic model(input logic rwb, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                         input logic [15:0] nm, input logic [15:0] sm, output logic en, output logic et);
        logic [12:0] steps[$];
        int k;
        en = 1'b0; et = 1'b0;
        exp_q.delete();
        steps.push_back({4'd1, 8'h00, 1'b0});
        steps.push_back({4'd4, d, 1'b0, 1'b0});
        steps.push_back({4'd4, r, 1'b0});
        if (!rwb) steps.push_back({4'd4, w, 1'b0});
        else begin
            steps.push_back({4'd2, 8'h00, 1'b0});
            steps.push_back({4'd4, d, 1'b1, 1'b0});
            steps.push_back({4'd5, 8'h00, 1'b1});
        end
        for (int i = 0; i < steps.size(); i++) begin
            exp_q.push_back(steps[i]);
            if (sm[i[3:0]]) begin et = 1'b1; break; end
            if (steps[i][12:9] == 4'd4 && nm[i[3:0]]) begin en = 1'b1; break; end
        end
        k = exp_q.size();
        exp_q.push_back({4'd3, 8'h00, 1'b0});
        if (sm[k[3:0]]) et = 1'b1;
    endtask

    task automatic run_txn(input string tag, input logic rwb, input logic [6:0] d, input logic [7:0] r,
                           input logic [7:0] w, input int rdy, input int dly, input logic [15:0] nm,
                           input logic [15:0] sm, input logic [7:0] rv, input int exp_delta, input bit poke);
        logic en, et;
        bit   seen;
        int   mism;
        cfg_rdy = rdy; cfg_dly = dly; cfg_nack = nm; cfg_stall = sm; cfg_rd = rv;
        log_q.delete(); done_pulses = 0; stab_viol = 0; tmo_delta = -1;
        model(rwb, d, r, w, nm, sm, en, et);
        @(negedge clk);
        rw = rwb; dev = d; ra = r; wd = w; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk({tag, ".busy_on_accept"}, int'(busy), 1);
        chk({tag, ".errs_clear_on_accept"}, int'({err_nack, err_tmo}), 0);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin req = 1'b1; wd = ~w; end
            else req = 1'b0;
            if (done) seen = 1'b1;
        end
        chk({tag, ".done_seen"}, int'(seen), 1);
        chk({tag, ".busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, int'(done), 0);
        repeat (6) @(negedge clk);
        chk({tag, ".done_pulses"}, done_pulses, 1);
        chk({tag, ".ncmds"}, log_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            if (log_q[i][12:9] !== exp_q[i][12:9]) mism++;
            else if (exp_q[i][12:9] == 4'd4 && log_q[i][8:1] !== exp_q[i][8:1]) mism++;
            else if (exp_q[i][12:9] == 4'd5 && log_q[i][0] !== exp_q[i][0]) mism++;
        end
        chk({tag, ".cmd_mismatches"}, mism, 0);
        chk({tag, ".err_nack"}, int'(err_nack), int'(en));
        chk({tag, ".err_tmo"}, int'(err_tmo), int'(et));
        chk({tag, ".stable_while_stalled"}, stab_viol, 0);
        if (rwb && !en && !et) chk({tag, ".rdata"}, int'(rdata), int'(rv));
        if (exp_delta >= 0) chk({tag, ".tmo_latency"}, tmo_delta, exp_delta);
        $display("txn %s rw=%0d dev=%h reg=%h wd=%h cmds=%0d nack=%0d tmo=%0d rdata=%h",
                 tag, rwb, d, r, w, log_q.size(), err_nack, err_tmo, rdata);
    endtask

    initial begin
        logic       r_rw;
        logic [6:0] r_dev;
        logic [7:0] r_reg, r_wd, r_rd;
        logic [15:0] r_nm, r_sm;

        repeat (3) @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.errs", int'({err_nack, err_tmo}), 0);
        chk("reset.cmd_valid", int'(cmd_valid), 0);
        chk("reset.cmd", int'(cmd), 0);
        chk("reset.cmd_byte_nack", int'({cmd_byte, cmd_nack}), 0);
        chk("reset.rdata", int'(rdata), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("wr",          1'b0, 7'h3C, 8'h10, 8'hA5, 0, 5, 16'h0000, 16'h0000, 8'h00, -1, 1'b0);
        run_txn("rd",          1'b1, 7'h50, 8'h02, 8'h00, 0, 5, 16'h0000, 16'h0000, 8'h5A, -1, 1'b0);
        run_txn("nack_dev",    1'b0, 7'h3C, 8'h10, 8'hA5, 0, 3, 16'h0002, 16'h0000, 8'h00, -1, 1'b0);
        run_txn("after_nack",  1'b0, 7'h3C, 8'h11, 8'h5A, 1, 2, 16'h0000, 16'h0000, 8'h00, -1, 1'b0);
        run_txn("tmo_reg",     1'b0, 7'h21, 8'h44, 8'h99, 0, 2, 16'h0000, 16'h0004, 8'h00, 20, 1'b0);
        run_txn("tmo_reg_stop",1'b0, 7'h21, 8'h44, 8'h99, 0, 2, 16'h0000, 16'h000C, 8'h00, 20, 1'b0);
        run_txn("rdy7_busyreq",1'b0, 7'h12, 8'h34, 8'h56, 7, 2, 16'h0000, 16'h0000, 8'h00, -1, 1'b1);

        for (int n = 0; n < 12; n++) begin
            r_rw  = 1'($urandom_range(0, 1));
            r_dev = 7'($urandom);
            r_reg = 8'($urandom);
            r_wd  = 8'($urandom);
            r_rd  = 8'($urandom);
            r_nm  = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(1, 4)) : 16'h0;
            r_sm  = ($urandom_range(0, 5) == 0) ? (16'h1 << $urandom_range(0, 6)) : 16'h0;
            run_txn($sformatf("rnd%0d", n), r_rw, r_dev, r_reg, r_wd,
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), r_nm, r_sm, r_rd, -1, 1'b0);
        end

        run_txn("rd_pre", 1'b1, 7'h29, 8'h33, 8'h00, 0, 2, 16'h0000, 16'h0000, 8'hC3, -1, 1'b0);

        // Reset while the device-read address byte is waiting for completion.
        cfg_rdy = 0; cfg_dly = 2; cfg_nack = 16'h0; cfg_stall = 16'h0010; cfg_rd = 8'h00;
        log_q.delete();
        @(negedge clk);
        rw = 1'b1; dev = 7'h29; ra = 8'h33; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 200 && log_q.size() < 5; i++) @(negedge clk);
        chk("midrst.reached_dev_r", log_q.size(), 5);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done_errs", int'({done, err_nack, err_tmo}), 0);
        chk("midrst.cmd_valid", int'(cmd_valid), 0);
        chk("midrst.cmd", int'({cmd, cmd_byte, cmd_nack}), 0);
        chk("midrst.rdata", int'(rdata), 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn("post_rst", 1'b1, 7'h29, 8'h33, 8'h00, 1, 3, 16'h0000, 16'h0000, 8'h7E, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Transaction-level controller above the byte/bit-level I2C engine (IIC engine commands IDLE/START/RESTART/STOP plus byte WRITE/READ). Accepts one register-access request (7-bit device address, 8-bit register address, R/W, write data). Breaks it into the engine command sequence. Reports read data, ACK/NACK errors and timeouts to the host logic. Sits between system control logic and the I2C engine.

Parameters:
P_TIMEOUT, 16'd50000, max i_clk cycles to wait for each engine command to complete before abort
P_CNT_W, 16, width of timeout counter (must hold P_TIMEOUT)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  request strobe; sampled only in IDLE
i_RW  in  1  0 = register write, 1 = register read
i_dev_addr  in  7  target device address
i_reg_addr  in  8  register address
i_W_data  in  8  write data (i_RW=0)
o_busy  out  1  high from request accept until o_done
o_done  out  1  one-cycle pulse at transaction end (success or error)
o_err_nack  out  1  sticky until next accept: slave NACKed a written byte
o_err_tmo  out  1  sticky until next accept: engine command timed out
o_R_data  out  8  read result, valid from o_done (i_RW=1, no error) until next accept
o_cmd  out  4  engine command: 0 IDLE, 1 START, 2 RESTART, 3 STOP, 4 WRITE, 5 READ
o_cmd_valid  out  1  command request to engine
o_cmd_byte  out  8  byte for WRITE
o_cmd_nack  out  1  for READ: 1 = master sends NACK after byte
i_cmd_ready  in  1  engine accepts command when valid & ready
i_cmd_done  in  1  one-cycle pulse: accepted command finished
i_ack  in  1  with i_cmd_done after WRITE: 1 = slave ACK, 0 = NACK
i_rd_byte  in  8  with i_cmd_done after READ: received byte

Behaviour:
- Reset (i_rst_n low, async): state IDLE; o_busy, o_done, o_err_nack, o_err_tmo, o_cmd_valid, o_cmd_nack = 0; o_cmd = 0 (IDLE); o_cmd_byte, o_R_data = 0; timeout counter = 0.
- IDLE: if i_req, latch i_RW/i_dev_addr/i_reg_addr/i_W_data, clear error flags, o_busy=1, go to START next cycle. i_req while busy is ignored.
- Each command step has two phases. ISSUE: o_cmd_valid=1, o_cmd/o_cmd_byte stable until the cycle valid&ready. WAIT: valid=0, await i_cmd_done.
- Timeout counter clears on entry to each ISSUE. It counts every cycle in ISSUE and WAIT. Reaching P_TIMEOUT sets o_err_tmo and goes to STOP.
- State order, write: START -> DEV_W (byte {dev,0}) -> REG (reg_addr) -> DATA_W (W_data) -> STOP -> DONE.
- State order, read: START -> DEV_W -> REG -> RESTART -> DEV_R (byte {dev,1}) -> READ (o_cmd_nack=1) -> STOP -> DONE.
- After any WRITE-type step, i_ack=0 at i_cmd_done sets o_err_nack and goes to STOP, skipping the remaining bytes.
- READ step: latch i_rd_byte into o_R_data at i_cmd_done.
- Timeout in STOP itself goes directly to DONE; a STOP is never reissued.
- DONE: o_done=1 for exactly one cycle, o_busy=0 the same cycle, return to IDLE. Minimum idle gap before the next accept: 1 cycle.
- i_cmd_done outside WAIT is ignored. i_cmd_done in the same cycle as valid&ready is not legal engine behaviour and need not be handled.
- Reset mid-transaction: immediate IDLE, o_cmd_valid drops; the bus is recovered by the engine's own reset.

Decomposition:
- Shared package i2c_pkg: engine command codes (CMD_IDLE=0, START=1, RESTART=2, STOP=3, WRITE=4, READ=5), R/W bit constants, sequencer state encoding.
- One natural sub-module: i2c_cmd_issue, a valid/ready issue plus done/timeout wait unit reused by every step. It returns done/ack/timeout to the main FSM.

Test Plan:
- Register write dev=0x3C reg=0x10 data=0xA5, engine always ACKs, ready immediate, done after 5 cycles -> commands START, WRITE 0x78, WRITE 0x10, WRITE 0xA5, STOP; one o_done pulse; no errors.
- Register read dev=0x50 reg=0x02, engine returns 0x5A -> START, WRITE 0xA0, WRITE 0x02, RESTART, WRITE 0xA1, READ nack=1, STOP; o_R_data=0x5A at o_done.
- NACK on device byte (i_ack=0 after WRITE 0x78) -> next command STOP, no REG write, o_err_nack=1, o_done pulse. o_err_nack clears on next accept.
- Engine never pulses done after REG with P_TIMEOUT=20 -> o_err_tmo exactly 20 cycles after ISSUE entry, STOP issued, then o_done. STOP also stalled -> DONE without a second STOP.
- i_cmd_ready held low 7 cycles -> o_cmd_valid and o_cmd/o_cmd_byte stable for all 7 cycles. i_req pulsed while busy -> ignored, no second transaction.
- i_rst_n asserted during DEV_R WAIT -> all outputs at reset values asynchronously. New request after release completes normally.
